reg_file: RTL
=============

Name: reg_file

Overview:
- Architectural integer register file with per-register rename tags for the out-of-order core.
- Sits directly downstream of the reorder buffer. Consumes its in-order commit stream (enable, register id, data, ROB id) and its flush pulse.
- Serves the decoder: combinational operand reads returning value plus pending ROB tag, and a rename port that marks a destination register as owned by a newly allocated ROB entry.

Parameters:
- ROB_WIDTH, 5, width of ROB ids. Id 0 means "no producer / ready"; valid ids are 1..2^ROB_WIDTH-1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- commit_enabled  input  1  ROB commit writes a register this cycle
- commit_reg_id  input  5  destination register of the commit
- commit_data  input  32  value to write
- commit_rob_id  input  ROB_WIDTH  ROB entry being committed
- flush_in  input  1  ROB mispredict/reset flush; all speculative tags are void
- rename_enabled  input  1  decoder issues an instruction with a destination register
- rename_reg_id  input  5  destination register being renamed
- rename_rob_id  input  ROB_WIDTH  ROB entry that will produce it
- rs1_id  input  5  operand 1 register
- rs2_id  input  5  operand 2 register
- rs1_value  output  32  operand 1 value (valid when rs1_tag==0)
- rs1_tag  output  ROB_WIDTH  ROB id producing rs1, 0 if ready
- rs2_value  output  32  operand 2 value
- rs2_tag  output  ROB_WIDTH  ROB id producing rs2, 0 if ready
- busy_count  output  6  number of registers with nonzero tag (registered)

Behaviour:
- State: data[1..31] (32b), tag[1..31] (ROB_WIDTH). x0 is not stored: reads return value 0, tag 0; writes and renames to x0 are ignored.
- Reset (rst_in high at posedge): all data=0, tags=0, busy_count=0. Takes priority over every other input that cycle.
- Commit, at posedge, when commit_enabled and commit_reg_id!=0:
  - data[r] <= commit_data unconditionally (in-order commit, so the latest architectural value).
  - tag[r] <= 0 only if tag[r]==commit_rob_id; otherwise a younger rename still owns r and the tag is kept.
- Rename, at posedge, when rename_enabled, rename_reg_id!=0, rename_rob_id!=0 and !flush_in: tag[r] <= rename_rob_id.
  - rename_rob_id==0 makes the rename a no-op.
- Same-register commit and rename in one cycle: data is written; tag ends as rename_rob_id (rename wins).
- Flush, at posedge with flush_in high: all tags <= 0. A commit in the same cycle still writes data. Rename is ignored.
- Reads are combinational, for each port independently:
  - id==0: value 0, tag 0.
  - else if flush_in: value data[id], tag 0.
  - else if commit_enabled && commit_reg_id==id && tag[id]==commit_rob_id: bypass; value commit_data, tag 0.
  - else: value data[id], tag tag[id].
  - Reads reflect pre-rename state. An instruction reading and renaming the same register in one cycle sees the old producer.
- busy_count is registered: next-cycle count of nonzero tags after all updates. Range 0..31. 0 after reset or flush.
- No handshakes. Every update takes effect in the cycle after the input posedge. Zero-latency reads, one-cycle write latency.

Test Plan:
- Reset, then rename x5 with rob 3; next cycle read rs1=x5 -> rs1_tag=3, busy_count=1. Commit x5/rob 3/data 0xDEADBEEF; same cycle rs1 read -> value 0xDEADBEEF, tag 0 (bypass). Next cycle data[5]=0xDEADBEEF, tag 0, busy_count=0.
- Rename x7 rob 4, then x7 rob 9; commit x7 rob 4 data 0x11 -> data[7]=0x11, rs2_tag stays 9, no bypass, busy_count stays 1.
- Same cycle: commit x8 rob 2 data 0x55 (tag[8]=2) and rename x8 rob 6 -> next cycle data[8]=0x55, tag[8]=6.
- Renames on x1..x4 (rob 1..4), then flush_in with commit x10 data 0x77 and rename x12 rob 5 -> all tags 0, data[10]=0x77, tag[12]=0, busy_count=0. During the flush cycle, reads of x1 return tag 0.
- Commit x0 data 0xFF and rename x0 rob 7 -> rs1=x0 reads value 0, tag 0. Rename x3 with rob id 0 -> tag[3] unchanged.
- Assert rst_in mid-stream with busy tags and simultaneous commit/rename -> all data and tags 0, busy_count=0 next cycle.

Source files
------------

// File: rtl/reg_file_if.sv
// Commit, rename and operand-read bundle between the ROB/decoder side and
// the architectural register file.
interface reg_file_if #(
    parameter int unsigned ROB_WIDTH = 5
);
    logic                 commit_enabled;
    logic [4:0]           commit_reg_id;
    logic [31:0]          commit_data;
    logic [ROB_WIDTH-1:0] commit_rob_id;
    logic                 flush_in;
    logic                 rename_enabled;
    logic [4:0]           rename_reg_id;
    logic [ROB_WIDTH-1:0] rename_rob_id;
    logic [4:0]           rs1_id;
    logic [4:0]           rs2_id;
    logic [31:0]          rs1_value;
    logic [ROB_WIDTH-1:0] rs1_tag;
    logic [31:0]          rs2_value;
    logic [ROB_WIDTH-1:0] rs2_tag;
    logic [5:0]           busy_count;

    modport master (
        output commit_enabled, commit_reg_id, commit_data, commit_rob_id,
        output flush_in,
        output rename_enabled, rename_reg_id, rename_rob_id,
        output rs1_id, rs2_id,
        input  rs1_value, rs1_tag, rs2_value, rs2_tag, busy_count
    );

    modport slave (
        input  commit_enabled, commit_reg_id, commit_data, commit_rob_id,
        input  flush_in,
        input  rename_enabled, rename_reg_id, rename_rob_id,
        input  rs1_id, rs2_id,
        output rs1_value, rs1_tag, rs2_value, rs2_tag, busy_count
    );
endinterface

// File: rtl/reg_file.sv
// Architectural integer register file with per-register ROB rename tags,
// commit bypass on operand reads, and a registered count of busy registers.
module reg_file #(
    parameter int unsigned ROB_WIDTH = 5
) (
    input  logic       clk_in,
    input  logic       rst_in,
    reg_file_if.slave  bus
);
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_ID_W = 5;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned NUM_RD   = 2;

    typedef logic [ROB_WIDTH-1:0] tag_t;

    logic [DATA_W-1:0]   data_q   [NUM_REGS];
    logic [DATA_W-1:0]   data_d   [NUM_REGS];
    tag_t                tag_q    [NUM_REGS];
    tag_t                tag_d    [NUM_REGS];
    logic [CNT_W-1:0]    busy_q;
    logic [CNT_W-1:0]    busy_d;

    logic [REG_ID_W-1:0] rd_id    [NUM_RD];
    logic [DATA_W-1:0]   rd_value [NUM_RD];
    tag_t                rd_tag   [NUM_RD];

    logic commit_hit;
    logic rename_hit;

    assign commit_hit = bus.commit_enabled && (bus.commit_reg_id != '0);
    assign rename_hit = bus.rename_enabled && (bus.rename_reg_id != '0)
                        && (bus.rename_rob_id != '0) && !bus.flush_in;

    // Next-state: flush voids tags, commit retires its own tag, rename wins last.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        if (bus.flush_in) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                tag_d[i] = '0;
            end
        end
        if (commit_hit) begin
            data_d[bus.commit_reg_id] = bus.commit_data;
            if (!bus.flush_in && (tag_q[bus.commit_reg_id] == bus.commit_rob_id)) begin
                tag_d[bus.commit_reg_id] = '0;
            end
        end
        if (rename_hit) begin
            tag_d[bus.rename_reg_id] = bus.rename_rob_id;
        end
    end

    always_comb begin
        busy_d = '0;
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (tag_d[i] != '0) begin
                busy_d = busy_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    // Operand reads see pre-update state, with bypass of a retiring producer.
    always_comb begin
        rd_id[0] = bus.rs1_id;
        rd_id[1] = bus.rs2_id;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            rd_value[p] = '0;
            rd_tag[p]   = '0;
            if (rd_id[p] != '0) begin
                if (bus.flush_in) begin
                    rd_value[p] = data_q[rd_id[p]];
                end else if (bus.commit_enabled && (bus.commit_reg_id == rd_id[p])
                             && (tag_q[rd_id[p]] == bus.commit_rob_id)) begin
                    rd_value[p] = bus.commit_data;
                end else begin
                    rd_value[p] = data_q[rd_id[p]];
                    rd_tag[p]   = tag_q[rd_id[p]];
                end
            end
        end
    end

    assign bus.rs1_value  = rd_value[0];
    assign bus.rs1_tag    = rd_tag[0];
    assign bus.rs2_value  = rd_value[1];
    assign bus.rs2_tag    = rd_tag[1];
    assign bus.busy_count = busy_q;
endmodule
